// File: rtl/pc_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_arbiter_if
// Description : Handshake bundle for the pc_arbiter merge stage. Two token
//               producers, one downstream consumer, latency feedback and
//               the activity flag.
//               The producer/consumer side of the bundle uses the master
//               modport; the arbiter uses the slave modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_arbiter_if #(
   parameter int PC_WIDTH            = 8,
   parameter int LATENCY_COUNT_WIDTH = 8
);
   // Producer 0
   logic                           in0_pc_valid;
   logic [PC_WIDTH:0]              in0_pc_and_current;
   logic                           in0_pc_ready;
   logic [LATENCY_COUNT_WIDTH-1:0] in0_pc_latency;
   // Producer 1
   logic                           in1_pc_valid;
   logic [PC_WIDTH:0]              in1_pc_and_current;
   logic                           in1_pc_ready;
   logic [LATENCY_COUNT_WIDTH-1:0] in1_pc_latency;
   // Downstream input port
   logic                           out_pc_valid;
   logic [PC_WIDTH:0]              out_pc_and_current;
   logic                           out_pc_ready;
   logic [LATENCY_COUNT_WIDTH-1:0] out_pc_latency;
   // Termination detection
   logic                           running;

   // Environment side: drives tokens, consumer ready and downstream latency
   modport master (
      output in0_pc_valid, in0_pc_and_current,
      input  in0_pc_ready, in0_pc_latency,
      output in1_pc_valid, in1_pc_and_current,
      input  in1_pc_ready, in1_pc_latency,
      input  out_pc_valid, out_pc_and_current,
      output out_pc_ready, out_pc_latency,
      input  running
   );

   // Arbiter side
   modport slave (
      input  in0_pc_valid, in0_pc_and_current,
      output in0_pc_ready, in0_pc_latency,
      input  in1_pc_valid, in1_pc_and_current,
      output in1_pc_ready, in1_pc_latency,
      output out_pc_valid, out_pc_and_current,
      input  out_pc_ready, out_pc_latency,
      output running
   );
endinterface
`default_nettype wire

// File: rtl/pc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pc_arbiter
// Description : Two-input merge stage in front of a basic block PC port.
//               Grants at most one producer per cycle (round-robin), stores
//               accepted tokens in a registered 2-entry FIFO whose head
//               drives the downstream port, forwards a saturating latency
//               estimate upstream and reports activity.
//               Optional macro PC_ARB_CURRENT_PRIO_EN: when both inputs are
//               valid and exactly one token is directed to the current
//               character (bit 0), that token wins over round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_arbiter #(
   parameter int PC_WIDTH            = 8,
   parameter int LATENCY_COUNT_WIDTH = 8
) (
   input  wire logic    clk,
   input  wire logic    reset,
   pc_arbiter_if.slave  bus
);

   localparam int TOKEN_WIDTH = PC_WIDTH + 1;
   localparam int LW          = LATENCY_COUNT_WIDTH;
   localparam int SUM_WIDTH   = LW + 2;

   localparam logic [1:0] FULL_COUNT = 2'd2;
   localparam logic [SUM_WIDTH-1:0] LAT_MAX = {2'b00, {LW{1'b1}}};

   // Buffer state
   logic [1:0][TOKEN_WIDTH-1:0] r_mem;
   logic                        r_head;
   logic                        r_tail;
   logic [1:0]                  r_count;
   logic                        r_rr_ptr;

   // Registered head view
   logic                        r_out_valid;
   logic [TOKEN_WIDTH-1:0]      r_out_data;

   // Arbitration
   logic                        w_can_push;
   logic                        w_any_valid;
   logic                        w_grant;
   logic                        w_ready0;
   logic                        w_ready1;

   // Next-state
   logic                        w_push;
   logic                        w_pop;
   logic [TOKEN_WIDTH-1:0]      w_push_data;
   logic [1:0][TOKEN_WIDTH-1:0] w_mem_next;
   logic                        w_head_next;
   logic                        w_tail_next;
   logic [1:0]                  w_count_next;
   logic                        w_out_valid_next;
   logic [TOKEN_WIDTH-1:0]      w_out_data_next;

   // Latency forwarding
   logic [SUM_WIDTH-1:0]        w_lat_sum;
   logic [LW-1:0]               w_lat;

   // Grant selection: single valid wins, otherwise round-robin (optionally
   // overridden by the directed-to-current bit). Only registered count and
   // rr_ptr plus the current valids feed the readies, so out_pc_ready has
   // no combinational path to them.
   always_comb begin
      w_can_push  = !reset && (r_count != FULL_COUNT);
      w_any_valid = bus.in0_pc_valid || bus.in1_pc_valid;
      w_grant     = 1'b0;
      if (bus.in0_pc_valid && bus.in1_pc_valid) begin
         w_grant = r_rr_ptr;
`ifdef PC_ARB_CURRENT_PRIO_EN
         if (bus.in0_pc_and_current[0] != bus.in1_pc_and_current[0]) begin
            w_grant = bus.in1_pc_and_current[0];
         end
`endif
      end else if (bus.in1_pc_valid) begin
         w_grant = 1'b1;
      end
      w_ready0 = w_can_push && w_any_valid && !w_grant;
      w_ready1 = w_can_push && w_any_valid &&  w_grant;
   end

   // FIFO next-state: write at tail on push, advance head on pop
   always_comb begin
      w_push      = (bus.in0_pc_valid && w_ready0) || (bus.in1_pc_valid && w_ready1);
      w_pop       = r_out_valid && bus.out_pc_ready;
      w_push_data = w_grant ? bus.in1_pc_and_current : bus.in0_pc_and_current;

      w_mem_next = r_mem;
      if (w_push) begin
         w_mem_next[r_tail] = w_push_data;
      end
      w_head_next  = r_head ^ w_pop;
      w_tail_next  = r_tail ^ w_push;
      w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};

      w_out_valid_next = (w_count_next != 2'd0);
      w_out_data_next  = w_out_valid_next ? w_mem_next[w_head_next] : '0;
   end

   // Upstream latency estimate: downstream estimate + occupancy + 1, saturating
   always_comb begin
      w_lat_sum = {2'b00, bus.out_pc_latency}
                + {{LW{1'b0}}, r_count}
                + SUM_WIDTH'(1);
      if (w_lat_sum > LAT_MAX) begin
         w_lat = {LW{1'b1}};
      end else begin
         w_lat = w_lat_sum[LW-1:0];
      end
   end

   // Buffer, pointer, round-robin and registered head update
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mem       <= '0;
         r_head      <= 1'b0;
         r_tail      <= 1'b0;
         r_count     <= 2'd0;
         r_rr_ptr    <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_mem       <= w_mem_next;
         r_head      <= w_head_next;
         r_tail      <= w_tail_next;
         r_count     <= w_count_next;
         if (w_push) begin
            r_rr_ptr <= ~w_grant;
         end
         r_out_valid <= w_out_valid_next;
         r_out_data  <= w_out_data_next;
      end
   end

   assign bus.in0_pc_ready       = w_ready0;
   assign bus.in1_pc_ready       = w_ready1;
   assign bus.in0_pc_latency     = w_lat;
   assign bus.in1_pc_latency     = w_lat;
   assign bus.out_pc_valid       = r_out_valid;
   assign bus.out_pc_and_current = r_out_data;
   assign bus.running            = (r_count != 2'd0) || w_any_valid;

endmodule
`default_nettype wire

// File: tb/tb_pc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_arbiter
// Description : Self-checking bench for pc_arbiter. A reference model
//               predicts readies, latency, running and the accepted token
//               stream; accepted tokens are queued and compared as the
//               downstream port pops them. Directed scenarios follow the
//               test plan, then a random phase and a drain.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_arbiter;

   localparam int PW = 8;
   localparam int LW = 8;

   logic clk;
   logic reset;

   pc_arbiter_if #(.PC_WIDTH(PW), .LATENCY_COUNT_WIDTH(LW)) bus ();

   pc_arbiter #(.PC_WIDTH(PW), .LATENCY_COUNT_WIDTH(LW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vectors     = 0;
   int n_miscompares = 0;

   // Reference model state
   int         m_count = 0;
   logic       m_rr    = 1'b0;
   logic [PW:0] sb_q[$];

   logic [PW:0] exp_rr [4];

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vectors++;
      if (got !== exp) begin
         n_miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [LW-1:0] sat_lat(input logic [LW-1:0] lat, input int cnt);
      int s;
      s = int'(lat) + cnt + 1;
      if (s > 255) s = 255;
      return LW'(s);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model and scoreboard, evaluated mid-cycle
   logic        mv0, mv1, msel, mcan, mpush, mpop;
   logic        e_r0, e_r1;
   logic [PW:0] md0, md1;
   initial begin
      forever begin
         @(negedge clk);
         mv0 = bus.in0_pc_valid;
         mv1 = bus.in1_pc_valid;
         md0 = bus.in0_pc_and_current;
         md1 = bus.in1_pc_and_current;
         mcan = !reset && (m_count < 2);
         if (mv0 && mv1) begin
            msel = m_rr;
`ifdef PC_ARB_CURRENT_PRIO_EN
            if (md0[0] != md1[0]) msel = md1[0];
`endif
         end else begin
            msel = mv1;
         end
         e_r0 = mcan && (mv0 || mv1) && !msel;
         e_r1 = mcan && (mv0 || mv1) &&  msel;
         check_value("ready0", 32'(bus.in0_pc_ready), 32'(e_r0));
         check_value("ready1", 32'(bus.in1_pc_ready), 32'(e_r1));
         check_value("out_valid", 32'(bus.out_pc_valid), 32'(m_count != 0));
         check_value("running", 32'(bus.running), 32'((m_count != 0) || mv0 || mv1));
         check_value("lat0", 32'(bus.in0_pc_latency), 32'(sat_lat(bus.out_pc_latency, m_count)));
         check_value("lat1", 32'(bus.in1_pc_latency), 32'(sat_lat(bus.out_pc_latency, m_count)));
         mpush = e_r0 || e_r1;
         mpop  = (m_count != 0) && bus.out_pc_ready;
         if (mpop) begin
            if (sb_q.size() == 0) check_value("sb_underflow", 32'd1, 32'd0);
            else check_value("out_token", 32'(bus.out_pc_and_current), 32'(sb_q.pop_front()));
         end
         if (reset) begin
            m_count = 0;
            m_rr    = 1'b0;
            sb_q.delete();
         end else begin
            if (mpush) begin
               sb_q.push_back(msel ? md1 : md0);
               m_rr = ~msel;
            end
            m_count = m_count + int'(mpush) - int'(mpop);
         end
      end
   end

   task automatic drain();
      bus.in0_pc_valid = 1'b0;
      bus.in1_pc_valid = 1'b0;
      bus.out_pc_ready = 1'b1;
      for (int i = 0; i < 10 && m_count != 0; i++) tick();
      check_value("drain", 32'(m_count), 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   int  idx;
   logic accepted;

   initial begin
      exp_rr = '{9'h002, 9'h004, 9'h002, 9'h004};
      reset = 1'b1;
      bus.in0_pc_valid = 1'b0;
      bus.in1_pc_valid = 1'b0;
      bus.in0_pc_and_current = '0;
      bus.in1_pc_and_current = '0;
      bus.out_pc_ready = 1'b0;
      bus.out_pc_latency = '0;
      repeat (3) tick();

      // Reset state
      @(negedge clk);
      check_value("rst_valid", 32'(bus.out_pc_valid), 32'd0);
      check_value("rst_data", 32'(bus.out_pc_and_current), 32'd0);
      check_value("rst_lat", 32'(bus.in0_pc_latency), 32'd1);
      tick();

      // Single token, immediate pop
      reset = 1'b0;
      bus.in0_pc_valid = 1'b1;
      bus.in0_pc_and_current = 9'h00B;
      bus.out_pc_ready = 1'b1;
      bus.out_pc_latency = 8'd3;
      @(negedge clk);
      check_value("t1_ready0", 32'(bus.in0_pc_ready), 32'd1);
      tick();
      bus.in0_pc_valid = 1'b0;
      @(negedge clk);
      check_value("t1_valid", 32'(bus.out_pc_valid), 32'd1);
      check_value("t1_data", 32'(bus.out_pc_and_current), 32'h00B);
      check_value("t1_lat0", 32'(bus.in0_pc_latency), 32'd5);
      check_value("t1_lat1", 32'(bus.in1_pc_latency), 32'd5);
      tick();
      @(negedge clk);
      check_value("t1_running", 32'(bus.running), 32'd0);
      tick();

      // Round-robin between two busy producers
      do_reset();
      bus.in0_pc_and_current = 9'h002;
      bus.in1_pc_and_current = 9'h004;
      bus.in0_pc_valid = 1'b1;
      bus.in1_pc_valid = 1'b1;
      bus.out_pc_ready = 1'b1;
      idx = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (c < 4) check_value("t2_one_ready", 32'(int'(bus.in0_pc_ready) + int'(bus.in1_pc_ready)), 32'd1);
         if (bus.out_pc_valid && idx < 4) begin
            check_value("t2_order", 32'(bus.out_pc_and_current), 32'(exp_rr[idx]));
            idx++;
         end
         tick();
         if (c == 3) begin
            bus.in0_pc_valid = 1'b0;
            bus.in1_pc_valid = 1'b0;
         end
      end
      check_value("t2_count", 32'(idx), 32'd4);
      drain();

      // Backpressure: fill to two, hold the third token
      bus.out_pc_ready = 1'b0;
      bus.in0_pc_valid = 1'b1;
      bus.in0_pc_and_current = 9'h010;
      @(negedge clk);
      check_value("t3_acc10", 32'(bus.in0_pc_ready), 32'd1);
      tick();
      bus.in0_pc_and_current = 9'h012;
      @(negedge clk);
      check_value("t3_acc12", 32'(bus.in0_pc_ready), 32'd1);
      tick();
      bus.in0_pc_and_current = 9'h014;
      bus.out_pc_latency = 8'hFE;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check_value("t3_full_r0", 32'(bus.in0_pc_ready), 32'd0);
         check_value("t3_full_r1", 32'(bus.in1_pc_ready), 32'd0);
         check_value("t3_sat_lat", 32'(bus.in0_pc_latency), 32'hFF);
         check_value("t3_head", 32'(bus.out_pc_and_current), 32'h010);
         tick();
      end
      bus.out_pc_latency = 8'd0;
      bus.out_pc_ready = 1'b1;
      accepted = 1'b0;
      for (int c = 0; c < 8 && !accepted; c++) begin
         @(negedge clk);
         accepted = bus.in0_pc_ready && bus.in0_pc_valid;
         tick();
      end
      check_value("t3_acc14", 32'(accepted), 32'd1);
      drain();

`ifdef PC_ARB_CURRENT_PRIO_EN
      // Directed-to-current priority beats round-robin
      do_reset();
      bus.in0_pc_and_current = 9'h008;
      bus.in1_pc_and_current = 9'h009;
      bus.in0_pc_valid = 1'b1;
      bus.in1_pc_valid = 1'b1;
      bus.out_pc_ready = 1'b1;
      @(negedge clk);
      check_value("t4_prio_r1", 32'(bus.in1_pc_ready), 32'd1);
      tick();
      bus.in1_pc_valid = 1'b0;
      @(negedge clk);
      check_value("t4_then_r0", 32'(bus.in0_pc_ready), 32'd1);
      tick();
      drain();
`endif

      // Reset while full discards buffered tokens
      bus.out_pc_ready = 1'b0;
      bus.in0_pc_valid = 1'b1;
      bus.in1_pc_valid = 1'b1;
      bus.in0_pc_and_current = 9'h021;
      bus.in1_pc_and_current = 9'h022;
      tick();
      tick();
      bus.in0_pc_valid = 1'b0;
      bus.in1_pc_valid = 1'b0;
      reset = 1'b1;
      tick();
      @(negedge clk);
      check_value("t5_valid_rst", 32'(bus.out_pc_valid), 32'd0);
      reset = 1'b0;
      bus.out_pc_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         @(negedge clk);
         check_value("t5_no_stale", 32'(bus.out_pc_valid), 32'd0);
      end
      tick();
      bus.in0_pc_and_current = 9'h030;
      bus.in1_pc_and_current = 9'h032;
      bus.in0_pc_valid = 1'b1;
      bus.in1_pc_valid = 1'b1;
      @(negedge clk);
      check_value("t5_rr_reset", 32'(bus.in0_pc_ready), 32'd1);
      tick();
      drain();

      // Random traffic
      for (int c = 0; c < 400; c++) begin
         bus.in0_pc_valid = 1'($urandom_range(0, 1));
         bus.in1_pc_valid = 1'($urandom_range(0, 1));
         bus.in0_pc_and_current = 9'($urandom);
         bus.in1_pc_and_current = 9'($urandom);
         bus.out_pc_ready = ($urandom_range(0, 3) != 0);
         bus.out_pc_latency = 8'($urandom);
         tick();
      end
      drain();
      check_value("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pc_arbiter.md
# pc_arbiter

Two-input, one-output merge stage in front of a basic block's PC input port. It accepts PC-and-direction tokens from two producers and grants at most one per cycle. Producers are typically a neighbouring basic block's output port and the global dispatch/feedback path. Accepted tokens go into a registered 2-entry buffer that drives the downstream input port. The stage forwards a latency estimate upstream and reports activity for termination detection.

## Interface
- PC_WIDTH, 8, program-counter width; tokens are PC_WIDTH+1 bits: {pc, is_directed_to_current}
- LATENCY_COUNT_WIDTH, 8, width of latency estimates
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- in0_pc_valid  in  1  producer 0 token valid
- in0_pc_and_current  in  PC_WIDTH+1  producer 0 token; bit 0 = directed to current character
- in0_pc_ready  out  1  token 0 accepted this cycle when high with valid
- in0_pc_latency  out  LATENCY_COUNT_WIDTH  latency estimate toward producer 0
- in1_pc_valid / in1_pc_and_current / in1_pc_ready / in1_pc_latency: same as in0, for producer 1
- out_pc_valid  out  1  buffer head valid
- out_pc_and_current  out  PC_WIDTH+1  buffer head token
- out_pc_ready  in  1  downstream consumes head
- out_pc_latency  in  LATENCY_COUNT_WIDTH  downstream latency estimate
- running  out  1  buffer non-empty or any input valid

## Operation
- Buffer: 2-entry FIFO with head/tail pointers and a count in 0..2. Push happens on (inX_pc_valid && inX_pc_ready). Pop happens on (out_pc_valid && out_pc_ready).
- Full: count==2. Both readies are low, with no push in the same cycle as a pop; the freed slot becomes usable from the next cycle. No combinational path from out_pc_ready to either inX_pc_ready.
- Grant, combinational, computed only when count<2 and reset low:
  - Only one input valid: that input wins.
  - Both inputs valid: winner is rr_ptr.
  - inX_pc_ready = grant==X. At most one ready is high per cycle. Ready may depend on valid; valid must never depend on ready.
- rr_ptr: 1-bit register, reset 0. On a push from input X, rr_ptr <= ~X. Otherwise it holds.
- Simultaneous push/pop:
  - count==1: count stays 1, head advances, new token lands at tail.
  - count==0: a pop is impossible because out_pc_valid is low.
- Pointers wrap modulo 2.
- Latency: inX_pc_latency = out_pc_latency + count + 1, saturating at 2^LATENCY_COUNT_WIDTH-1. Both producers see the same value.
- running = (count!=0) || in0_pc_valid || in1_pc_valid.
- Reset values:
  - count=0, rr_ptr=0, pointers=0, storage=0.
  - out_pc_valid=0, out_pc_and_current=0.
  - in0/in1_pc_ready=0 while reset is high.
  - inX_pc_latency = saturated out_pc_latency+1.
  - running reflects input valids only.
- Reset mid-operation: buffered tokens are discarded and no token is emitted on the following cycle.

## Timing
- Latency: a token accepted at edge k is visible on out_pc_and_current after edge k with out_pc_valid=1, when the buffer was empty.
- Throughput: 1 token/cycle sustained while out_pc_ready is held high.
- out_pc_valid and out_pc_and_current are registered.
- inX_pc_ready is a function of the registered count, registered rr_ptr and the current valids.
- Head token and valid stay stable until popped.

## Configuration
- PC_ARB_CURRENT_PRIO_EN
  - Defined, both inputs valid:
    - Exactly one token has bit 0 = 1 (directed to current character): that input wins regardless of rr_ptr.
    - Both tokens have the same bit 0: the round-robin rule applies.
    - rr_ptr updates as usual after the push.
  - Undefined: pure round-robin as in Operation; bit 0 is ignored for arbitration.

## Test plan
- Reset, then in0 valid with token 0x0B, out_pc_ready=1:
  - in0_pc_ready=1 in the first cycle after reset release.
  - Next cycle out_pc_and_current=0x0B, out_pc_valid=1.
  - running drops after the pop.
- Both inputs valid for 4 cycles (in0=0x02, in1=0x04), out_pc_ready=1, macro undefined: output order 0x02,0x04,0x02,0x04; exactly one ready high per cycle.
- out_pc_ready=0, in0 valid continuously with 0x10, 0x12, 0x14:
  - Readies fall after 2 pushes; count=2; 0x14 is held.
  - Raise out_pc_ready: 0x10, 0x12, 0x14 appear in order with no loss or duplication.
- Macro defined, rr_ptr=0, in0=0x08 (bit0=0), in1=0x09 (bit0=1): in1 granted first, then in0.
- out_pc_latency=0xFE with count=2: inX_pc_latency=0xFF (saturated). With out_pc_latency=3 and count=1: inX_pc_latency=5.
- Assert reset while count=2: the next cycle has out_pc_valid=0, count=0 and rr_ptr=0, and no stale token is emitted after reset release.
